// File: rtl/pq_symbol_serializer_pkg.sv
// Shared types and defaults for the PQ symbol serializer.
// Symbol width is fixed at 4 bits; word length is parameterised.
package foo_pkg;

  localparam int pq_symbols = 8;

  typedef logic [3:0] symbol_4b_t;

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

endpackage

// File: rtl/pq_symbol_serializer.sv
// Serializes a word of PQ_SYMBOLS 4-bit symbols, index 0 first,
// with valid/ready on both sides and a synchronous flush.
module pq_symbol_serializer
  import foo_pkg::*;
#(
  parameter int PQ_SYMBOLS = pq_symbols
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_en,
  input  logic [PQ_SYMBOLS*4-1:0]       i_all_symbols_4b,
  output logic                          o_in_ready,
  input  logic                          i_flush,
  output logic                          o_valid,
  output logic [3:0]                    o_symbol_4b,
  output logic [$clog2(PQ_SYMBOLS)-1:0] o_idx,
  output logic                          o_last,
  input  logic                          i_ready
);

  localparam int IW = $clog2(PQ_SYMBOLS);
  localparam int WW = PQ_SYMBOLS * 4;
  localparam logic [IW-1:0] LAST = IW'(PQ_SYMBOLS - 1);

  state_t        state_q;
  state_t        state_d;
  logic [WW-1:0] hold_q;
  logic [IW-1:0] idx_q;
  logic          last_q;
  logic          live_q;
  logic          at_last;
  logic          advance;
  logic          load;
  symbol_4b_t    sym;

  assign at_last = idx_q == LAST;
  assign advance = (state_q == SHIFT) && i_ready;

  always_comb begin
    state_d    = state_q;
    o_in_ready = 1'b0;
    unique case (state_q)
      IDLE:  o_in_ready = live_q;
      SHIFT: o_in_ready = at_last && i_ready;
    endcase
    if (i_flush) o_in_ready = 1'b0;
    load = i_en && o_in_ready;
    if (i_flush) begin
      state_d = IDLE;
    end else if (load) begin
      state_d = SHIFT;
    end else if (advance && at_last) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // live_q keeps o_in_ready low until the first edge after reset
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) live_q <= 1'b0;
    else       live_q <= 1'b1;
  end

  // Holding register shifts right so the current symbol is always in [3:0]
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      hold_q <= '0;
      idx_q  <= '0;
      last_q <= 1'b0;
    end else if (i_flush) begin
      hold_q <= '0;
      idx_q  <= '0;
      last_q <= 1'b0;
    end else if (load) begin
      hold_q <= i_all_symbols_4b;
      idx_q  <= '0;
      last_q <= 1'b0;
    end else if (advance) begin
      if (at_last) begin
        hold_q <= '0;
        idx_q  <= '0;
        last_q <= 1'b0;
      end else begin
        hold_q <= hold_q >> 4;
        idx_q  <= idx_q + IW'(1);
        last_q <= (idx_q + IW'(1)) == LAST;
      end
    end
  end

  assign sym         = symbol_4b_t'(hold_q[3:0]);
  assign o_symbol_4b = sym;
  assign o_valid     = state_q == SHIFT;
  assign o_idx       = idx_q;
  assign o_last      = last_q;

endmodule

// File: tb/tb_pq_symbol_serializer.sv
// Bench for pq_symbol_serializer: directed scenarios plus a
// randomized run against a symbol-queue reference model.
module tb_pq_symbol_serializer;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en = 1'b0;
  logic [N*4-1:0] word = '0;
  logic         in_ready;
  logic         flush = 1'b0;
  logic         valid;
  logic [3:0]   sym;
  logic [2:0]   idx;
  logic         last;
  logic         ready = 1'b1;

  int checks = 0;
  int passes = 0;

  typedef struct {
    logic [3:0] s;
    int         i;
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;

  pq_symbol_serializer #(.PQ_SYMBOLS(N)) dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_en(en),
    .i_all_symbols_4b(word),
    .o_in_ready(in_ready),
    .i_flush(flush),
    .o_valid(valid),
    .o_symbol_4b(sym),
    .o_idx(idx),
    .o_last(last),
    .i_ready(ready)
  );

  task automatic test_reset();
    @(negedge clk);
    #1;
    checks++;
    if ({valid, in_ready, idx, sym, last} !== 10'd0)
      $display("FAIL rst_hold got v=%0b r=%0b i=%0d s=%h l=%0b want all 0",
               valid, in_ready, idx, sym, last);
    else passes++;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b0) $display("FAIL rst_rel0 got %0b want 0", in_ready);
    else passes++;
    @(negedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1) $display("FAIL rst_rel1 got %0b want 1", in_ready);
    else passes++;
    // mid-word reset at idx 3
    ready = 1'b1;
    en = 1'b1;
    word = 32'h7654_3210;
    @(negedge clk);
    en = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (idx !== 3'd3 || valid !== 1'b1)
      $display("FAIL rst_setup got idx=%0d v=%0b want 3 1", idx, valid);
    else passes++;
    #1 rst = 1'b1;
    #1;
    checks++;
    if (valid !== 1'b0 || idx !== 3'd0 || sym !== 4'd0 || in_ready !== 1'b0)
      $display("FAIL rst_async got v=%0b i=%0d s=%h r=%0b want 0 0 0 0",
               valid, idx, sym, in_ready);
    else passes++;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b0 || valid !== 1'b0)
      $display("FAIL rst_mid_rel0 got r=%0b v=%0b want 0 0", in_ready, valid);
    else passes++;
    @(negedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1 || valid !== 1'b0)
      $display("FAIL rst_mid_rel1 got r=%0b v=%0b want 1 0", in_ready, valid);
    else passes++;
  endtask

  task automatic test_single();
    @(negedge clk);
    ready = 1'b1;
    en = 1'b1;
    word = 32'h7654_3210;
    @(negedge clk);
    en = 1'b0;
    for (int k = 0; k < N; k++) begin
      #1;
      checks++;
      if (valid !== 1'b1 || sym !== 4'(k) || idx !== 3'(k) ||
          last !== (k == N - 1))
        $display("FAIL single[%0d] got v=%0b s=%h i=%0d l=%0b want 1 %h %0d %0b",
                 k, valid, sym, idx, last, 4'(k), k, k == N - 1);
      else passes++;
      @(negedge clk);
    end
    #1;
    checks++;
    if (valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL single_idle got v=%0b r=%0b want 0 1", valid, in_ready);
    else passes++;
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    ready = 1'b1;
    en = 1'b1;
    word = 32'h7654_3210;
    @(negedge clk);
    word = 32'hFEDC_BA98;
    for (int k = 0; k < 2 * N; k++) begin
      #1;
      checks++;
      if (valid !== 1'b1 || sym !== 4'(k) || idx !== 3'(k % N))
        $display("FAIL b2b[%0d] got v=%0b s=%h i=%0d want 1 %h %0d",
                 k, valid, sym, idx, 4'(k), k % N);
      else passes++;
      if (k == N - 1) begin
        checks++;
        if (in_ready !== 1'b1) $display("FAIL b2b_rdy got %0b want 1", in_ready);
        else passes++;
      end
      @(negedge clk);
      if (k == N - 1) en = 1'b0;
    end
    #1;
    checks++;
    if (valid !== 1'b0) $display("FAIL b2b_idle got v=%0b want 0", valid);
    else passes++;
  endtask

  task automatic test_backpressure();
    int         es[11] = '{0, 1, 2, 2, 2, 2, 3, 4, 5, 6, 7};
    logic [10:0] rp = 11'b111_1110_0011;
    @(negedge clk);
    ready = 1'b1;
    en = 1'b1;
    word = 32'h7654_3210;
    @(negedge clk);
    en = 1'b0;
    for (int c = 0; c < 11; c++) begin
      ready = rp[c];
      #1;
      checks++;
      if (valid !== 1'b1 || sym !== 4'(es[c]) || idx !== 3'(es[c]) ||
          last !== (es[c] == N - 1))
        $display("FAIL bp[%0d] got v=%0b s=%h i=%0d l=%0b want 1 %h %0d %0b",
                 c, valid, sym, idx, last, 4'(es[c]), es[c], es[c] == N - 1);
      else passes++;
      @(negedge clk);
    end
    ready = 1'b1;
    #1;
    checks++;
    if (valid !== 1'b0) $display("FAIL bp_idle got v=%0b want 0", valid);
    else passes++;
  endtask

  task automatic test_flush();
    @(negedge clk);
    ready = 1'b1;
    en = 1'b1;
    word = 32'h7654_3210;
    @(negedge clk);
    en = 1'b0;
    repeat (4) @(negedge clk);
    flush = 1'b1;
    en = 1'b1;
    word = 32'hA5A5_A5A5;
    #1;
    checks++;
    if (in_ready !== 1'b0 || sym !== 4'd4 || valid !== 1'b1)
      $display("FAIL flush_cyc got r=%0b s=%h v=%0b want 0 4 1",
               in_ready, sym, valid);
    else passes++;
    @(negedge clk);
    flush = 1'b0;
    en = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (valid !== 1'b0 || idx !== 3'd0 || sym !== 4'd0)
        $display("FAIL flush_after[%0d] got v=%0b i=%0d s=%h want 0 0 0",
                 c, valid, idx, sym);
      else passes++;
      @(negedge clk);
    end
  endtask

  task automatic test_scoreboard();
    logic exp_rdy;
    exp_t e;
    q.delete();
    for (int c = 0; c < 10000; c++) begin
      @(negedge clk);
      en    = ($urandom_range(99) < 50);
      ready = ($urandom_range(99) < 70);
      flush = ($urandom_range(99) < 3);
      word  = $urandom;
      #1;
      exp_rdy = !flush && (q.size() == 0 || (q.size() == 1 && ready));
      checks++;
      if (in_ready !== exp_rdy || valid !== (q.size() != 0))
        $display("FAIL sb_ctl[%0d] got r=%0b v=%0b want %0b %0b",
                 c, in_ready, valid, exp_rdy, q.size() != 0);
      else passes++;
      if (!flush && ready && q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if (sym !== e.s || idx !== 3'(e.i) || last !== (e.i == N - 1))
          $display("FAIL sb_sym[%0d] got s=%h i=%0d l=%0b want %h %0d %0b",
                   c, sym, idx, last, e.s, e.i, e.i == N - 1);
        else passes++;
      end
      if (flush) q.delete();
      if (!flush && en && exp_rdy)
        for (int k = 0; k < N; k++) q.push_back('{word[4*k +: 4], k});
    end
    @(negedge clk);
    en = 1'b0;
    flush = 1'b0;
    ready = 1'b1;
    for (int c = 0; c < 2 * N && q.size() > 0; c++) begin
      #1;
      e = q.pop_front();
      checks++;
      if (valid !== 1'b1 || sym !== e.s || idx !== 3'(e.i))
        $display("FAIL sb_drain got v=%0b s=%h i=%0d want 1 %h %0d",
                 valid, sym, idx, e.s, e.i);
      else passes++;
      @(negedge clk);
    end
    #1;
    checks++;
    if (valid !== 1'b0 || q.size() != 0)
      $display("FAIL sb_end got v=%0b left=%0d want 0 0", valid, q.size());
    else passes++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_scoreboard();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/pq_symbol_serializer.md
PQ_SYMBOL_SERIALIZER -- requirements
Module: pq_symbol_serializer

Interface
REQ-001 SHALL have parameter PQ_SYMBOLS, default foo_pkg::pq_symbols, number of 4-bit symbols per input word (legal 2..64).
REQ-002 SHALL have port i_clk, input, 1, sole clock; all state on rising edge.
REQ-003 SHALL have port i_rst, input, 1, reset, asynchronous and active-high.
REQ-004 SHALL have port i_en, input, 1, input word valid.
REQ-005 SHALL have port i_all_symbols_4b, input, PQ_SYMBOLS*4, parallel symbol word; symbol k at bits [4k+3:4k].
REQ-006 SHALL have port o_in_ready, output, 1, word accepted on the cycle where i_en && o_in_ready.
REQ-007 SHALL have port i_flush, input, 1, synchronous discard of the word in flight.
REQ-008 SHALL have port o_valid, output, 1, o_symbol_4b valid.
REQ-009 SHALL have port o_symbol_4b, output, 4, current symbol.
REQ-010 SHALL have port o_idx, output, $clog2(PQ_SYMBOLS), index of current symbol.
REQ-011 SHALL have port o_last, output, 1, high with the symbol at index PQ_SYMBOLS-1.
REQ-012 SHALL have port i_ready, input, 1, downstream accepts symbol on i_ready && o_valid.

Function
REQ-013 SHALL implement FSM with states IDLE and SHIFT.
REQ-014 In IDLE: o_in_ready=1, o_valid=0; i_en -> capture word into holding register, idx=0, next SHIFT.
REQ-015 In SHIFT: o_valid=1, o_symbol_4b = held symbol[idx], registered outputs, no combinational input->output path except o_in_ready.
REQ-016 Symbol handshake: idx SHALL advance by 1 only on i_ready && o_valid; with i_ready low, o_symbol_4b, o_idx, o_last SHALL hold stable.
REQ-017 Emission order SHALL be index 0 first through PQ_SYMBOLS-1 last.
REQ-018 o_in_ready SHALL be 1 in SHIFT exactly when idx==PQ_SYMBOLS-1 && i_ready (back-to-back words, no bubble).
REQ-019 Last symbol accepted with i_en high: load new word, idx=0, stay SHIFT; with i_en low: go IDLE.
REQ-020 Throughput SHALL be one symbol per cycle under continuous i_ready; latency i_en accept -> first o_valid = 1 cycle.
REQ-021 i_flush SHALL force IDLE next cycle, o_valid=0, held word discarded; o_in_ready SHALL be 0 while i_flush high; i_flush has priority over any handshake in the same cycle.
REQ-022 i_en while o_in_ready=0 SHALL be ignored (upstream must hold); no word SHALL be lost or duplicated.
REQ-023 idx SHALL never exceed PQ_SYMBOLS-1; wrap to 0 only via REQ-019.

Reset
REQ-024 i_rst high SHALL asynchronously force IDLE, idx=0, holding register=0, o_valid=0, o_symbol_4b=0, o_idx=0, o_last=0, o_in_ready=0.
REQ-025 o_in_ready SHALL rise first clock edge after i_rst deasserts; reset mid-word SHALL drop the word without emitting further symbols.

Structure
REQ-026 foo_pkg SHALL hold pq_symbols, typedef symbol_4b_t (logic [3:0]) and typedef state enum {IDLE, SHIFT}.
REQ-027 Block SHALL be one module, no sub-modules; holding register + counter + 2-state FSM.

Verification
REQ-028 Reset: i_rst=1 mid-SHIFT at idx=3 -> o_valid=0, o_idx=0 immediately; o_in_ready=1 one cycle after release.
REQ-029 Single word, PQ_SYMBOLS=8, word 0x76543210, i_ready=1 -> symbols 0,1..7 on 8 consecutive cycles, o_last only with 7, then IDLE.
REQ-030 Back-to-back: words 0x76543210 then 0xFEDCBA98 with i_en held -> 16 contiguous symbols 0..F, no gap.
REQ-031 Backpressure: i_ready low 3 cycles at idx=2 -> symbol 2 held stable 4 cycles, then 3..7 continue.
REQ-032 Flush: i_flush at idx=4 with i_en=1 -> no symbols 5..7, o_valid=0 next cycle, i_en word not accepted that cycle.
REQ-033 Scoreboard: random i_en/i_ready/i_flush 10k cycles -> output symbol stream equals accepted words in order minus flushed tails.
